// File: rtl/regdst_pipe.sv
// regdst_pipe: write-back register index select plus a DEPTH-stage
// valid-tagged pipeline (stall/flush) with RAW hazard scoreboard.
// Optional feature macro: REGDST_ZERO_SUPPRESS_EN. When it is defined,
// register 0 never counts as a write and is never reported as a hazard.
module regdst_pipe #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 3,
   parameter int SP_IDX = 29,
   parameter int RA_IDX = 31
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [1:0]                   regdst,
   input  logic [ADDR_W-1:0]            rt_in,
   input  logic [ADDR_W-1:0]            rd_in,
   input  logic                         wr_en_in,
   input  logic                         in_valid,
   input  logic                         stall,
   input  logic                         flush,
   input  logic [ADDR_W-1:0]            rs_chk,
   input  logic [ADDR_W-1:0]            rt_chk,
   output logic [ADDR_W-1:0]            dest_out,
   output logic                         dest_valid,
   output logic                         wr_en_out,
   output logic                         hazard_rs,
   output logic                         hazard_rt,
   output logic [$clog2(DEPTH+1)-1:0]   pending_cnt
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   // Per-stage state: stage 0 is the youngest entry, DEPTH-1 the oldest.
   logic              valid_reg [DEPTH];
   logic [ADDR_W-1:0] dest_reg  [DEPTH];
   logic              wr_en_reg [DEPTH];

   logic [ADDR_W-1:0] sel_idx;
   logic              wr_en_next;

   logic [DEPTH-1:0]  pend;
   logic [DEPTH-1:0]  match_rs;
   logic [DEPTH-1:0]  match_rt;

   // Destination index select ahead of stage 0.
   always_comb begin
      sel_idx = rt_in;
      case (regdst)
         2'b00:   sel_idx = rt_in;
         2'b01:   sel_idx = rd_in;
         2'b10:   sel_idx = ADDR_W'(SP_IDX);
         default: sel_idx = ADDR_W'(RA_IDX);
      endcase
   end

`ifdef REGDST_ZERO_SUPPRESS_EN
   // Writes to $zero are architecturally void, so store them as non-writing.
   assign wr_en_next = wr_en_in & (sel_idx != '0);
`else
   assign wr_en_next = wr_en_in;
`endif

   // Pipeline shift with priority reset > flush > stall > advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_reg[i] <= 1'b0;
            dest_reg[i]  <= '0;
            wr_en_reg[i] <= 1'b0;
         end
      end else if (flush) begin
         // Entry presented this cycle is dropped too; dest fields are left as-is.
         for (int i = 0; i < DEPTH; i++) begin
            valid_reg[i] <= 1'b0;
         end
      end else if (!stall) begin
         valid_reg[0] <= in_valid;
         dest_reg[0]  <= sel_idx;
         wr_en_reg[0] <= wr_en_next;
         for (int i = 1; i < DEPTH; i++) begin
            valid_reg[i] <= valid_reg[i-1];
            dest_reg[i]  <= dest_reg[i-1];
            wr_en_reg[i] <= wr_en_reg[i-1];
         end
      end
   end

   // Per-stage pending-write and operand-match terms.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         assign pend[gi]     = valid_reg[gi] & wr_en_reg[gi];
         assign match_rs[gi] = pend[gi] & (dest_reg[gi] == rs_chk);
         assign match_rt[gi] = pend[gi] & (dest_reg[gi] == rt_chk);
      end
   endgenerate

   // Hazard flags from registered state only; the input entry is not included.
   always_comb begin
`ifdef REGDST_ZERO_SUPPRESS_EN
      hazard_rs = (|match_rs) & (rs_chk != '0);
      hazard_rt = (|match_rt) & (rt_chk != '0);
`else
      hazard_rs = |match_rs;
      hazard_rt = |match_rt;
`endif
   end

   // Population count of pending writes, including the last stage.
   always_comb begin
      pending_cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (pend[i]) begin
            pending_cnt = pending_cnt + CNT_W'(1);
         end
      end
   end

   assign dest_out   = dest_reg[DEPTH-1];
   assign dest_valid = valid_reg[DEPTH-1];
   assign wr_en_out  = valid_reg[DEPTH-1] & wr_en_reg[DEPTH-1];

endmodule

// File: tb/tb_regdst_pipe.sv
// Scoreboard bench for regdst_pipe (DEPTH=3): stimulus pushes the
// hand-computed retiring entry; a negedge monitor pops on each retirement.
module tb_regdst_pipe;

   localparam int ADDR_W = 5;
   localparam int DEPTH  = 3;

`ifdef REGDST_ZERO_SUPPRESS_EN
   localparam bit ZS = 1'b1;
`else
   localparam bit ZS = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [1:0]        regdst = 2'b00;
   logic [ADDR_W-1:0] rt_in = '0;
   logic [ADDR_W-1:0] rd_in = '0;
   logic              wr_en_in = 1'b0;
   logic              in_valid = 1'b0;
   logic              stall = 1'b0;
   logic              flush = 1'b0;
   logic [ADDR_W-1:0] rs_chk = 5'd30;
   logic [ADDR_W-1:0] rt_chk = 5'd30;
   logic [ADDR_W-1:0] dest_out;
   logic              dest_valid;
   logic              wr_en_out;
   logic              hazard_rs;
   logic              hazard_rt;
   logic [1:0]        pending_cnt;

   typedef struct packed {
      logic [ADDR_W-1:0] dest;
      logic              wr_en;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;

   regdst_pipe #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SP_IDX(29), .RA_IDX(31)) dut (
      .clk(clk), .reset(reset), .regdst(regdst), .rt_in(rt_in), .rd_in(rd_in),
      .wr_en_in(wr_en_in), .in_valid(in_valid), .stall(stall), .flush(flush),
      .rs_chk(rs_chk), .rt_chk(rt_chk), .dest_out(dest_out),
      .dest_valid(dest_valid), .wr_en_out(wr_en_out), .hazard_rs(hazard_rs),
      .hazard_rt(hazard_rt), .pending_cnt(pending_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end else begin
         $display("ok   %s: %0d (t=%0t)", name, act, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one entry and record what must eventually retire.
   task automatic issue(input logic [1:0] sel, input logic [4:0] rt, input logic [4:0] rd,
                        input logic we, input logic [4:0] exp_dest, input logic exp_we);
      exp_t e;
      regdst   = sel;
      rt_in    = rt;
      rd_in    = rd;
      wr_en_in = we;
      in_valid = 1'b1;
      e.dest   = exp_dest;
      e.wr_en  = exp_we;
      exp_q.push_back(e);
   endtask

   // Monitor: an entry retires at the next edge when it is valid and the pipe advances.
   always @(negedge clk) begin
      if (!reset && !flush && !stall && dest_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL retire_unexpected: got dest %0d, required no entry (t=%0t)", dest_out, $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("retire_dest", 32'(dest_out), 32'(mon_e.dest));
            check("retire_wr_en", 32'(wr_en_out), 32'(mon_e.wr_en));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required finish before 100000");
      $fatal(1);
   end

   initial begin
      logic [4:0] sel_exp [4];
      sel_exp = '{5'd5, 5'd12, 5'd29, 5'd31};

      // Reset state
      tick();
      tick();
      check("rst_dest_out", 32'(dest_out), 0);
      check("rst_dest_valid", 32'(dest_valid), 0);
      check("rst_wr_en_out", 32'(wr_en_out), 0);
      check("rst_hazard_rs", 32'(hazard_rs), 0);
      check("rst_hazard_rt", 32'(hazard_rt), 0);
      check("rst_pending", 32'(pending_cnt), 0);
      reset = 1'b0;

      // Selection: four sources back to back, valid on cycles 3..6
      for (int k = 1; k <= 7; k++) begin
         if (k <= 4) issue(2'(k - 1), 5'd5, 5'd12, 1'b1, sel_exp[k-1], 1'b1);
         else in_valid = 1'b0;
         tick();
         check("sel_valid", 32'(dest_valid), 32'(k >= 3 && k <= 6));
      end
      in_valid = 1'b0;

      // Hazard tracking of one writing entry through all stages
      rs_chk = 5'd12;
      rt_chk = 5'd7;
      issue(2'b01, 5'd5, 5'd12, 1'b1, 5'd12, 1'b1);
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         check("haz_rs", 32'(hazard_rs), 32'(k <= 3));
         check("haz_rt", 32'(hazard_rt), 0);
         check("haz_pending", 32'(pending_cnt), 32'(k <= 3));
         tick();
      end

      // Stall: entry 8 frozen, rd=9 offered during stall must not enter
      rs_chk = 5'd30;
      rt_chk = 5'd30;
      issue(2'b01, 5'd0, 5'd8, 1'b1, 5'd8, 1'b1);
      tick();
      stall = 1'b1;
      rd_in = 5'd9;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("stall_valid", 32'(dest_valid), 0);
         check("stall_pending", 32'(pending_cnt), 1);
      end
      stall    = 1'b0;
      in_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("stall_out_valid", 32'(dest_valid), 32'(k == 2));
         check("stall_out_pending", 32'(pending_cnt), 32'(k <= 2));
      end

      // Flush coincident with a new entry
      rs_chk = 5'd2;
      for (int j = 0; j < 3; j++) begin
         issue(2'b01, 5'd0, 5'(j + 1), 1'b1, 5'(j + 1), 1'b1);
         tick();
      end
      check("pre_flush_pending", 32'(pending_cnt), 3);
      flush    = 1'b1;
      in_valid = 1'b1;
      rd_in    = 5'd4;
      exp_q.delete();
      tick();
      check("flush_valid", 32'(dest_valid), 0);
      check("flush_pending", 32'(pending_cnt), 0);
      check("flush_hazard_rs", 32'(hazard_rs), 0);
      flush    = 1'b0;
      in_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         check("post_flush_valid", 32'(dest_valid), 0);
         check("post_flush_pending", 32'(pending_cnt), 0);
      end

      // Reset with two entries pending, oldest already at the output
      rs_chk = 5'd29;
      issue(2'b10, 5'd0, 5'd0, 1'b1, 5'd29, 1'b1);
      tick();
      issue(2'b11, 5'd0, 5'd0, 1'b1, 5'd31, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      check("pre_rst_pending", 32'(pending_cnt), 2);
      check("pre_rst_hazard_rs", 32'(hazard_rs), 1);
      check("pre_rst_dest_out", 32'(dest_out), 29);
      reset = 1'b1;
      exp_q.delete();
      tick();
      reset = 1'b0;
      check("mid_rst_dest_out", 32'(dest_out), 0);
      check("mid_rst_valid", 32'(dest_valid), 0);
      check("mid_rst_wr_en_out", 32'(wr_en_out), 0);
      check("mid_rst_hazard_rs", 32'(hazard_rs), 0);
      check("mid_rst_pending", 32'(pending_cnt), 0);

      // Register zero as destination
      rs_chk = 5'd0;
      rt_chk = 5'd31;
      issue(2'b00, 5'd0, 5'd5, 1'b1, 5'd0, ZS ? 1'b0 : 1'b1);
      tick();
      in_valid = 1'b0;
      check("zero_hazard_rs", 32'(hazard_rs), ZS ? 0 : 1);
      check("zero_hazard_rt", 32'(hazard_rt), 0);
      check("zero_pending", 32'(pending_cnt), ZS ? 0 : 1);
      repeat (5) tick();

      check("scoreboard_drained", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
